mips_mem_arbiter: RTL and testbench
===================================

MIPS_MEM_ARBITER -- requirements
Module: MIPS_MEM_ARBITER

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while fetch waits.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have port GlobalClock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port GlobalReset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_req  in  1  instruction-fetch read request.
REQ-007 SHALL have port i_addr  in  AW  fetch address.
REQ-008 SHALL have port i_rdata  out  DW  fetched word.
REQ-009 SHALL have port i_done  out  1  fetch complete, one-cycle pulse.
REQ-010 SHALL have port d_req  in  1  data-stage request.
REQ-011 SHALL have port d_we  in  1  1=store, 0=load.
REQ-012 SHALL have port d_addr  in  AW  data address.
REQ-013 SHALL have port d_wdata  in  DW  store data.
REQ-014 SHALL have port d_rdata  out  DW  load data.
REQ-015 SHALL have port d_done  out  1  data access complete, one-cycle pulse.
REQ-016 SHALL have port m_req  out  1  shared-memory request.
REQ-017 SHALL have port m_we  out  1  shared-memory write enable.
REQ-018 SHALL have port m_addr  out  AW  shared-memory address.
REQ-019 SHALL have port m_wdata  out  DW  shared-memory write data.
REQ-020 SHALL have port m_rdata  in  DW  shared-memory read data, valid with m_ack.
REQ-021 SHALL have port m_ack  in  1  shared-memory completion; latency 0..N cycles after m_req.
REQ-022 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE.
REQ-024 IDLE transitions: eligible request present -> BUSY_I or BUSY_D per REQ-026; no eligible request -> stay IDLE.
REQ-025 A port SHALL be eligible only when its req=1 and it is not pulsing done in the current cycle.
REQ-026 Arbitration SHALL give data priority, except fetch wins when both are eligible and the streak counter equals STARVE_MAX.
REQ-027 Streak counter, width clog2(STARVE_MAX+1): increments on a data grant while i_req=1; clears on a fetch grant, and on a data grant while i_req=0; saturates at STARVE_MAX.
REQ-028 On grant, m_addr/m_we/m_wdata SHALL register the winner's inputs; fetch grants force m_we=0; m_* SHALL be held stable through the BUSY state.
REQ-029 m_req SHALL be 1 exactly while in BUSY_I or BUSY_D.
REQ-030 BUSY_x with m_ack=1 -> DONE, capturing m_rdata into x_rdata (captured for loads only; d_rdata unchanged on stores); m_ack=0 -> stay.
REQ-031 DONE SHALL pulse i_done or d_done for exactly one cycle, then go to IDLE (no new grant decided in DONE).
REQ-032 Latency: req seen in IDLE at cycle t, m_ack at t+1 -> done at t+2; each extra wait cycle adds one.
REQ-033 m_ack while m_req=0 SHALL be ignored.
REQ-034 x_rdata SHALL hold its last captured value until the next completed read on that port.
REQ-035 Requesters hold req/addr/wdata stable until done; the arbiter SHALL not re-sample them mid-transaction.

Reset
REQ-036 GlobalReset=1 at an edge SHALL force: state IDLE, streak 0, m_req/m_we/i_done/d_done/busy 0, m_addr/m_wdata/i_rdata/d_rdata all 0.
REQ-037 Reset during BUSY SHALL abandon the transaction: m_req low the next cycle, no done pulse issued.

Structure
REQ-038 The state enum and port-select encoding (SEL_I=0, SEL_D=1) SHALL live in shared package mips_core_pkg.
REQ-039 Winner selection SHALL be one combinational sub-module MIPS_ARB_PICK (inputs: eligible flags, streak-at-max; output: select/valid); FSM and registers stay in the top.

Verification
REQ-040 Fetch only: i_req=1, i_addr=0x40, m_ack at t+1 with m_rdata=0x8C010004 -> i_done at t+2, i_rdata=0x8C010004, m_we=0.
REQ-041 Both eligible in IDLE, streak 0: d_req store to 0x100, data 0xDEADBEEF -> m_we=1, m_addr=0x100, d_done first, fetch served next.
REQ-042 Both held continuously, STARVE_MAX=4, immediate ack -> grant order D,D,D,D,I,D,...; no port waits more than 5 grants.
REQ-043 m_ack delayed 3 cycles -> m_req and m_addr stable 4 cycles; done 5 cycles after request; busy=1 throughout.
REQ-044 GlobalReset asserted in BUSY_D -> next cycle m_req=0, state IDLE, no d_done; a fresh d_req completes normally.
REQ-045 Spurious m_ack in IDLE -> no done, no rdata change; req held during the done cycle -> no regrant in that cycle.

Source files
------------

// File: rtl/mips_core_pkg.sv
// -----------------------------------------------------------------------------
// mips_core_pkg
// Shared definitions for the MIPS core memory path.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D, DONE)
//   SEL_I/SEL_D : port-select encoding used by the winner picker
//   is_busy_st  : helper, true while a shared-memory access is in flight
// -----------------------------------------------------------------------------
package mips_core_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    // True in the states that own the shared memory bus.
    function automatic logic is_busy_st(input arb_state_e st);
        return (st == BUSY_I) || (st == BUSY_D);
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mips_arb_pick
// Combinational winner selection between the fetch and data requesters.
// Data has priority; fetch wins only when both are eligible and the data
// streak has reached its limit, so fetch cannot starve.
//   fetch_elig_s : fetch port eligible
//   data_elig_s  : data port eligible
//   at_max_s     : data streak counter equals its limit
//   sel_s        : SEL_I or SEL_D (meaningful when valid_s=1)
//   valid_s      : some port is granted
// -----------------------------------------------------------------------------
module mips_arb_pick
    import mips_core_pkg::*;
(
    input  logic fetch_elig_s,
    input  logic data_elig_s,
    input  logic at_max_s,
    output logic sel_s,
    output logic valid_s
);

    // Priority decision with anti-starvation override.
    always_comb begin
        sel_s   = SEL_D;
        valid_s = 1'b0;
        if (fetch_elig_s && data_elig_s) begin
            valid_s = 1'b1;
            sel_s   = at_max_s ? SEL_I : SEL_D;
        end else if (data_elig_s) begin
            valid_s = 1'b1;
            sel_s   = SEL_D;
        end else if (fetch_elig_s) begin
            valid_s = 1'b1;
            sel_s   = SEL_I;
        end else begin
            valid_s = 1'b0;
            sel_s   = SEL_D;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_mem_arbiter
// Arbitrates one shared single-port memory between instruction fetch and the
// data stage. One transaction at a time: IDLE -> BUSY_x -> DONE -> IDLE.
//   GlobalClock, GlobalReset : clock, synchronous active-high reset
//   i_req/i_addr             : fetch request in; i_rdata/i_done out
//   d_req/d_we/d_addr/d_wdata: data request in; d_rdata/d_done out
//   m_req/m_we/m_addr/m_wdata: shared-memory request out
//   m_rdata/m_ack            : shared-memory completion in
//   busy                     : high in any state other than IDLE
// -----------------------------------------------------------------------------
module mips_mem_arbiter
    import mips_core_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          GlobalClock,
    input  logic          GlobalReset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    arb_state_e    state_r, state_n;
    logic [SW-1:0] streak_r;
    logic [AW-1:0] m_addr_r;
    logic          m_we_r;
    logic [DW-1:0] m_wdata_r;
    logic [DW-1:0] i_rdata_r, d_rdata_r;
    logic          m_req_r, busy_r, i_done_r, d_done_r;
    logic          m_req_s, busy_s, i_done_s, d_done_s;
    logic          fetch_elig_s, data_elig_s, at_max_s;
    logic          pick_sel_s, pick_valid_s, grant_s;

    // A port that is pulsing done this cycle must not be regranted yet.
    assign fetch_elig_s = i_req && !i_done_r;
    assign data_elig_s  = d_req && !d_done_r;
    assign at_max_s     = (streak_r == STREAK_MAX);
    assign grant_s      = (state_r == IDLE) && pick_valid_s;

    mips_arb_pick u_pick (
        .fetch_elig_s (fetch_elig_s),
        .data_elig_s  (data_elig_s),
        .at_max_s     (at_max_s),
        .sel_s        (pick_sel_s),
        .valid_s      (pick_valid_s)
    );

    // FSM state register.
    always_ff @(posedge GlobalClock) begin
        if (GlobalReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic; grants are only decided in IDLE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_n = (pick_sel_s == SEL_I) ? BUSY_I : BUSY_D;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack) begin
                    state_n = DONE;
                end else begin
                    state_n = state_r;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM output decode from the next state, so the flops below present
    // outputs aligned with the state register.
    always_comb begin
        m_req_s  = is_busy_st(state_n);
        busy_s   = (state_n != IDLE);
        i_done_s = 1'b0;
        d_done_s = 1'b0;
        if (state_n == DONE) begin
            i_done_s = (state_r == BUSY_I);
            d_done_s = (state_r == BUSY_D);
        end else begin
            i_done_s = 1'b0;
            d_done_s = 1'b0;
        end
    end

    // Registered control outputs; reset clears them so an abandoned
    // transaction never produces a done pulse.
    always_ff @(posedge GlobalClock) begin
        if (GlobalReset) begin
            m_req_r  <= 1'b0;
            busy_r   <= 1'b0;
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end else begin
            m_req_r  <= m_req_s;
            busy_r   <= busy_s;
            i_done_r <= i_done_s;
            d_done_r <= d_done_s;
        end
    end

    // Request capture at grant, streak tracking, and read-data capture.
    // m_* only load at a grant, so they stay frozen through BUSY.
    always_ff @(posedge GlobalClock) begin
        if (GlobalReset) begin
            streak_r  <= {SW{1'b0}};
            m_addr_r  <= {AW{1'b0}};
            m_we_r    <= 1'b0;
            m_wdata_r <= {DW{1'b0}};
            i_rdata_r <= {DW{1'b0}};
            d_rdata_r <= {DW{1'b0}};
        end else begin
            if (grant_s) begin
                if (pick_sel_s == SEL_I) begin
                    m_addr_r <= i_addr;
                    m_we_r   <= 1'b0;
                    streak_r <= {SW{1'b0}};
                end else begin
                    m_addr_r  <= d_addr;
                    m_we_r    <= d_we;
                    m_wdata_r <= d_wdata;
                    // Count data wins only while fetch is actually waiting.
                    if (!i_req) begin
                        streak_r <= {SW{1'b0}};
                    end else if (!at_max_s) begin
                        streak_r <= streak_r + SW'(1);
                    end
                end
            end
            if ((state_r == BUSY_I) && m_ack) begin
                i_rdata_r <= m_rdata;
            end
            if ((state_r == BUSY_D) && m_ack && !m_we_r) begin
                d_rdata_r <= m_rdata;
            end
        end
    end

    assign m_req   = m_req_r;
    assign busy    = busy_r;
    assign i_done  = i_done_r;
    assign d_done  = d_done_r;
    assign m_addr  = m_addr_r;
    assign m_we    = m_we_r;
    assign m_wdata = m_wdata_r;
    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_arbiter
// Directed self-checking bench for mips_mem_arbiter (default parameters).
// -----------------------------------------------------------------------------
module tb_mips_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        busy;

    int total;
    int bad;

    mips_mem_arbiter #(.STARVE_MAX(4), .AW(32), .DW(32)) dut (
        .GlobalClock (clk),
        .GlobalReset (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_done      (i_done),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ack       (m_ack),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    logic [31:0] order_exp [6];

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        m_rdata = 32'h0;
        m_ack   = 1'b0;

        // Reset state.
        tick();
        tick();
        chk1 ("rst_m_req",   m_req,   1'b0);
        chk1 ("rst_busy",    busy,    1'b0);
        chk1 ("rst_i_done",  i_done,  1'b0);
        chk1 ("rst_d_done",  d_done,  1'b0);
        chk1 ("rst_m_we",    m_we,    1'b0);
        chk32("rst_m_addr",  m_addr,  32'h0);
        chk32("rst_m_wdata", m_wdata, 32'h0);
        chk32("rst_i_rdata", i_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Fetch only, ack one cycle after grant.
        i_req  = 1'b1;
        i_addr = 32'h0000_0040;
        tick();
        chk1 ("f_m_req",  m_req,  1'b1);
        chk32("f_m_addr", m_addr, 32'h0000_0040);
        chk1 ("f_m_we",   m_we,   1'b0);
        chk1 ("f_busy",   busy,   1'b1);
        chk1 ("f_nodone", i_done, 1'b0);
        m_ack   = 1'b1;
        m_rdata = 32'h8C01_0004;
        tick();
        chk1 ("f_i_done",  i_done,  1'b1);
        chk32("f_i_rdata", i_rdata, 32'h8C01_0004);
        chk1 ("f_m_req_done", m_req, 1'b0);
        m_ack = 1'b0;
        i_req = 1'b0;
        tick();
        chk1 ("f_done_pulse", i_done, 1'b0);
        chk1 ("f_idle_busy",  busy,   1'b0);

        // Both eligible: data store wins, fetch served next.
        i_req   = 1'b1;
        i_addr  = 32'h0000_0044;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0100;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        chk1 ("b_m_we",    m_we,    1'b1);
        chk32("b_m_addr",  m_addr,  32'h0000_0100);
        chk32("b_m_wdata", m_wdata, 32'hDEAD_BEEF);
        m_ack   = 1'b1;
        m_rdata = 32'h1234_5678;
        tick();
        chk1 ("b_d_done",   d_done,  1'b1);
        chk1 ("b_no_i",     i_done,  1'b0);
        chk32("b_st_rdata", d_rdata, 32'h0);
        m_ack = 1'b0;
        d_req = 1'b0;
        tick();
        chk1 ("b_idle_req", m_req, 1'b0);
        tick();
        chk1 ("b_f_req",  m_req,  1'b1);
        chk32("b_f_addr", m_addr, 32'h0000_0044);
        chk1 ("b_f_we",   m_we,   1'b0);
        m_ack   = 1'b1;
        m_rdata = 32'hCAFE_F00D;
        tick();
        chk1 ("b_i_done",  i_done,  1'b1);
        chk32("b_i_rdata", i_rdata, 32'hCAFE_F00D);
        m_ack = 1'b0;
        i_req = 1'b0;
        tick();

        // Load with ack delayed three cycles.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0200;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk1 ("w_m_req",  m_req,  1'b1);
            chk32("w_m_addr", m_addr, 32'h0000_0200);
            chk1 ("w_busy",   busy,   1'b1);
            chk1 ("w_nodone", d_done, 1'b0);
            if (k == 3) begin
                m_ack   = 1'b1;
                m_rdata = 32'h0BAD_F00D;
            end
            tick();
        end
        chk1 ("w_d_done",  d_done,  1'b1);
        chk32("w_d_rdata", d_rdata, 32'h0BAD_F00D);
        chk1 ("w_busy_done", busy,  1'b1);
        m_ack = 1'b0;
        d_req = 1'b0;
        tick();

        // Spurious ack while idle is ignored.
        m_ack   = 1'b1;
        m_rdata = 32'hFFFF_FFFF;
        tick();
        chk1 ("s_m_req",   m_req,   1'b0);
        chk1 ("s_i_done",  i_done,  1'b0);
        chk1 ("s_d_done",  d_done,  1'b0);
        chk32("s_i_rdata", i_rdata, 32'hCAFE_F00D);
        chk32("s_d_rdata", d_rdata, 32'h0BAD_F00D);
        m_ack = 1'b0;

        // Request held through done: no regrant during the done cycle.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0300;
        tick();
        chk1 ("h_m_req", m_req, 1'b1);
        m_ack   = 1'b1;
        m_rdata = 32'h1111_1111;
        tick();
        chk1 ("h_d_done", d_done, 1'b1);
        m_ack = 1'b0;
        tick();
        chk1 ("h_noregrant", m_req, 1'b0);
        chk1 ("h_idle",      busy,  1'b0);
        chk32("h_d_rdata",   d_rdata, 32'h1111_1111);
        tick();
        chk1 ("h_regrant", m_req, 1'b1);
        m_ack   = 1'b1;
        m_rdata = 32'h2222_2222;
        tick();
        chk1 ("h_d_done2", d_done, 1'b1);
        m_ack = 1'b0;
        d_req = 1'b0;
        tick();

        // Reset in BUSY_D abandons the store; a fresh request then completes.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0400;
        d_wdata = 32'h0000_0055;
        tick();
        chk1 ("r_m_req_busy", m_req, 1'b1);
        rst = 1'b1;
        tick();
        chk1 ("r_m_req",  m_req,  1'b0);
        chk1 ("r_busy",   busy,   1'b0);
        chk1 ("r_d_done", d_done, 1'b0);
        chk32("r_m_addr", m_addr, 32'h0);
        rst = 1'b0;
        tick();
        chk32("r_new_addr", m_addr, 32'h0000_0400);
        chk1 ("r_new_req",  m_req,  1'b1);
        m_ack = 1'b1;
        tick();
        chk1 ("r_new_done", d_done, 1'b1);
        m_ack = 1'b0;
        d_req = 1'b0;
        tick();

        // Starvation bound: both held, immediate ack -> D,D,D,D,I,D.
        order_exp[0] = 32'h0000_0500;
        order_exp[1] = 32'h0000_0500;
        order_exp[2] = 32'h0000_0500;
        order_exp[3] = 32'h0000_0500;
        order_exp[4] = 32'h0000_0040;
        order_exp[5] = 32'h0000_0500;
        i_req   = 1'b1;
        i_addr  = 32'h0000_0040;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0500;
        d_wdata = 32'h0000_00AA;
        m_ack   = 1'b1;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk1 ("o_m_req",  m_req,  1'b1);
            chk32("o_order",  m_addr, order_exp[g]);
            tick();
            tick();
        end
        m_ack = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk1("o_end_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
